dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped data-cache controller that sits directly upstream of the 128-entry, 12-bit data-cache tag RAM.
- Issues tag reads, consumes the tag RAM's registered compare output and decides hit or miss.
- Owns the valid-bit array, refills lines from memory and writes tags back on refill.
- Write-through, no-write-allocate; one outstanding CPU request.

Parameters:
- SETS, 128, number of cache lines; index width is 7.
- LINE_WORDS, 4, 32-bit words per line; word-offset width is 2.
- TAG_W, 12, tag width.

Ports:
- clk  in  1  clock; all state updates on posedge
- nReset  in  1  asynchronous active-low reset
- cpu_req  in  1  request strobe, sampled in IDLE only
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  23  byte address: [22:11] tag, [10:4] index, [3:2] word, [1:0] byte
- cpu_wdata  in  32  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_busy  out  1  high whenever state is not IDLE
- tag_re  out  1  to tag RAM ReadEnable
- tag_rindex  out  7  to tag RAM CacheIndexRead
- tag_we  out  1  to tag RAM WriteTag
- tag_windex  out  7  to tag RAM CacheIndexWrite
- tag_wdata  out  12  to tag RAM WriteAddressTag
- tag_rdata  in  12  from tag RAM TagCompare; valid the cycle after tag_re
- dram_we  out  1  data-RAM word write strobe
- dram_addr  out  9  {index, word}
- dram_wdata  out  32  data-RAM write data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write (write-through)
- mem_addr  out  23  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  one-cycle acknowledge; read data valid in the same cycle
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (async, nReset=0):
  - state=IDLE; all 128 valid bits cleared.
  - All outputs 0, including cpu_ready, mem_req, tag_we, dram_we.
  - Reset mid-refill abandons the line: mem_req drops immediately, the line's valid bit stays 0, and no tag write occurs.
- Latched request: on acceptance, addr/we/wdata are registered (lat_*); the cpu_* inputs are ignored until the next IDLE.
- IDLE:
  - On cpu_req=1: latch the request, assert tag_re=1 with tag_rindex=cpu_addr[10:4] combinationally, go to LOOKUP.
  - Otherwise tag_re=0.
- LOOKUP: hit = valid[lat_idx] & (tag_rdata == lat_tag).
  - Load hit: cpu_ready=1 this cycle, go to IDLE. Load-hit latency is 2 cycles from cpu_req.
  - Load miss: go to REFILL with word counter cnt=0.
  - Store, hit or miss: on hit, dram_we=1 with dram_addr={lat_idx, lat_word} and dram_wdata=lat_wdata in this cycle. Go to WRITE_THRU either way.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={lat_tag, lat_idx, cnt, 2'b00}.
  - On each mem_ack: dram_we=1, dram_addr={lat_idx, cnt}, dram_wdata=mem_rdata, then cnt++.
  - mem_req stays high between words; the address updates the cycle after each ack.
  - On the ack with cnt==LINE_WORDS-1, in the same cycle: tag_we=1, tag_windex=lat_idx, tag_wdata=lat_tag, set valid[lat_idx]=1. Go to REISSUE.
  - cnt wraps to 0.
- REISSUE: tag_re=1, tag_rindex=lat_idx; go to LOOKUP. The second lookup is a guaranteed hit and completes the load.
- WRITE_THRU:
  - mem_req=1, mem_we=1, mem_addr={lat_addr[22:2], 2'b00}, mem_wdata=lat_wdata.
  - On mem_ack: cpu_ready=1, go to IDLE. Valid bits and tags are unchanged.
- Simultaneous events:
  - cpu_req during a non-IDLE state is ignored; the CPU must hold it until cpu_ready.
  - mem_ack outside REFILL/WRITE_THRU is ignored.
- tag_we and tag_re never assert in the same cycle.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits (32), stat_misses (32) and input stat_clr (1).
  - Counters clear on reset or stat_clr.
  - Increment once per first LOOKUP of a request: hits on load hit or store hit, misses on load miss or store miss.
  - The REISSUE lookup is not counted. Counters saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then load addr 0x000010 (idx 1, tag 0) -> miss.
  - Expect 4 mem reads at 0x000010, 0x000014, 0x000018, 0x00001C.
  - Expect tag_we with windex=1, wdata=0.
  - Expect cpu_ready 2 cycles after the last ack.
- Repeat load 0x000014 -> cpu_ready exactly 2 cycles after cpu_req, mem_req stays 0.
- Load 0x000810 (tag 1, idx 1) after the above -> conflict miss, refill, tag_wdata=1; a subsequent load to 0x000010 misses again.
- Store 0xDEADBEEF to 0x000014 while the line is valid -> dram_we at addr {1,1}, mem write at 0x000014, no tag_we, valid bit unchanged.
- Store to 0x7FF000 (never filled) -> no dram_we, one mem write, cpu_ready on ack; a following load to 0x7FF000 misses.
- Assert nReset=0 after the 2nd refill ack, then release -> mem_req=0 immediately, state IDLE; reloading the same address misses and refills all 4 words.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Bus bundle between the data-cache controller and its CPU, tag RAM, data RAM and memory.
// Statistics signals exist only when DCACHE_STATS_EN is defined.
interface dcache_ctrl_if;
  // CPU side
  logic        cpu_req;
  logic        cpu_we;
  logic [22:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_busy;
  // Tag RAM
  logic        tag_re;
  logic [6:0]  tag_rindex;
  logic        tag_we;
  logic [6:0]  tag_windex;
  logic [11:0] tag_wdata;
  logic [11:0] tag_rdata;
  // Data RAM
  logic        dram_we;
  logic [8:0]  dram_addr;
  logic [31:0] dram_wdata;
  // Memory
  logic        mem_req;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  // Controller side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, tag_rdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_busy, tag_re, tag_rindex, tag_we, tag_windex, tag_wdata,
    output dram_we, dram_addr, dram_wdata, mem_req, mem_we, mem_addr, mem_wdata
`ifdef DCACHE_STATS_EN
    , input stat_clr, output stat_hits, stat_misses
`endif
  );

  // Environment side (CPU, RAMs, memory)
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, tag_rdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_busy, tag_re, tag_rindex, tag_we, tag_windex, tag_wdata,
    input  dram_we, dram_addr, dram_wdata, mem_req, mem_we, mem_addr, mem_wdata
`ifdef DCACHE_STATS_EN
    , output stat_clr, input stat_hits, stat_misses
`endif
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller (128 x 4-word lines).
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl (
  input logic          clk,
  input logic          nReset,
  dcache_ctrl_if.slave bus
);
  localparam int SETS       = 128;
  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 12;
  localparam int IDX_W      = $clog2(SETS);
  localparam int WORD_W     = $clog2(LINE_WORDS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOOKUP     = 3'd1;
  localparam logic [2:0] S_REFILL     = 3'd2;
  localparam logic [2:0] S_REISSUE    = 3'd3;
  localparam logic [2:0] S_WRITE_THRU = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [22:0]       lat_addr_q;
  logic              lat_we_q;
  logic [31:0]       lat_wdata_q;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q;

  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_word;
  logic              accept;
  logic              hit;
  logic              refill_ack;
  logic              refill_done;

  assign lat_tag     = lat_addr_q[22:11];
  assign lat_idx     = lat_addr_q[10:4];
  assign lat_word    = lat_addr_q[3:2];
  // Reset also masks the combinational IDLE path so every output reads 0 while held in reset.
  assign accept      = nReset && (state_q == S_IDLE) && bus.cpu_req;
  assign hit         = valid_q[lat_idx] && (bus.tag_rdata == lat_tag);
  assign refill_ack  = (state_q == S_REFILL) && bus.mem_ack;
  assign refill_done = refill_ack && (cnt_q == WORD_W'(LINE_WORDS - 1));

  logic              cpu_ready;
  logic              tag_re;
  logic [IDX_W-1:0]  tag_rindex;
  logic              tag_we;
  logic [IDX_W-1:0]  tag_windex;
  logic [TAG_W-1:0]  tag_wdata;
  logic              dram_we;
  logic [8:0]        dram_addr;
  logic [31:0]       dram_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [22:0]       mem_addr;
  logic [31:0]       mem_wdata;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpu_ready  = 1'b0;
    tag_re     = 1'b0;
    tag_rindex = '0;
    tag_we     = 1'b0;
    tag_windex = '0;
    tag_wdata  = '0;
    dram_we    = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_re     = 1'b1;
          tag_rindex = bus.cpu_addr[10:4];
          state_d    = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (lat_we_q) begin
          if (hit) begin
            dram_we    = 1'b1;
            dram_addr  = {lat_idx, lat_word};
            dram_wdata = lat_wdata_q;
          end
          state_d = S_WRITE_THRU;
        end else if (hit) begin
          cpu_ready = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end

      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_idx, cnt_q, 2'b00};
        if (refill_ack) begin
          dram_we    = 1'b1;
          dram_addr  = {lat_idx, cnt_q};
          dram_wdata = bus.mem_rdata;
          cnt_d      = cnt_q + 1'b1;
        end
        if (refill_done) begin
          tag_we     = 1'b1;
          tag_windex = lat_idx;
          tag_wdata  = lat_tag;
          state_d    = S_REISSUE;
        end
      end

      S_REISSUE: begin
        tag_re     = 1'b1;
        tag_rindex = lat_idx;
        state_d    = S_LOOKUP;
      end

      S_WRITE_THRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {lat_addr_q[22:2], 2'b00};
        mem_wdata = lat_wdata_q;
        if (bus.mem_ack) begin
          cpu_ready = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_addr_q  <= bus.cpu_addr;
        lat_we_q    <= bus.cpu_we;
        lat_wdata_q <= bus.cpu_wdata;
      end
    end
  end

  // NOTE: the valid array is reset (unlike the tag/data RAMs) because it alone decides what is cached.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      valid_q <= '0;
    end else if (refill_done) begin
      valid_q[lat_idx] <= 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        reissue_q;
  logic [31:0] stat_hits_q;
  logic [31:0] stat_misses_q;
  logic        first_lookup;

  // Only the lookup triggered directly by the CPU request is counted, never the post-refill one.
  assign first_lookup = (state_q == S_LOOKUP) && !reissue_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      reissue_q     <= 1'b0;
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      if (accept) begin
        reissue_q <= 1'b0;
      end else if (refill_done) begin
        reissue_q <= 1'b1;
      end

      if (bus.stat_clr) begin
        stat_hits_q   <= '0;
        stat_misses_q <= '0;
      end else if (first_lookup) begin
        if (hit && (stat_hits_q != '1)) begin
          stat_hits_q <= stat_hits_q + 1'b1;
        end
        if (!hit && (stat_misses_q != '1)) begin
          stat_misses_q <= stat_misses_q + 1'b1;
        end
      end
    end
  end

  assign bus.stat_hits   = stat_hits_q;
  assign bus.stat_misses = stat_misses_q;
`endif

  assign bus.cpu_ready  = cpu_ready;
  assign bus.cpu_busy   = (state_q != S_IDLE);
  assign bus.tag_re     = tag_re;
  assign bus.tag_rindex = tag_rindex;
  assign bus.tag_we     = tag_we;
  assign bus.tag_windex = tag_windex;
  assign bus.tag_wdata  = tag_wdata;
  assign bus.dram_we    = dram_we;
  assign bus.dram_addr  = dram_addr;
  assign bus.dram_wdata = dram_wdata;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores push expected bus events,
// a negedge monitor pops and compares each event the DUT produces.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus)
  );

`ifdef DCACHE_STATS_EN
  initial bus.stat_clr = 1'b0;
`endif

  typedef enum logic [1:0] {EV_MEM, EV_DRAM, EV_TAG, EV_READY} ev_kind_e;
  // For EV_READY, w selects the latency reference: 0 = from request cycle (inclusive), 1 = from last ack.
  typedef struct packed {
    ev_kind_e    kind;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  int  req_cyc  = 0;
  int  ack_cyc  = 0;
  int  n_acks   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input logic [22:0] a);
    return 32'hC0DE_0000 ^ {9'd0, a};
  endfunction

  task automatic exp_ev(input ev_kind_e k, input logic w, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.w    = w;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic exp_refill(input logic [22:0] addr, input int nwords, input bit with_tag);
    logic [22:0] wa;
    logic [1:0]  wi;
    for (int i = 0; i < nwords; i++) begin
      wa = {addr[22:4], 4'b0000} + 23'(i * 4);
      wi = 2'(i);
      exp_ev(EV_MEM, 1'b0, {9'd0, wa}, 32'd0);
      exp_ev(EV_DRAM, 1'b0, {23'd0, addr[10:4], wi}, mdat(wa));
      if (with_tag && i == 3) exp_ev(EV_TAG, 1'b0, {25'd0, addr[10:4]}, {20'd0, addr[22:11]});
    end
  endtask

  task automatic exp_load(input logic [22:0] addr, input bit hit);
    if (hit) begin
      exp_ev(EV_READY, 1'b0, 32'd0, 32'd2);
    end else begin
      exp_refill(addr, 4, 1'b1);
      exp_ev(EV_READY, 1'b1, 32'd0, 32'd2);
    end
  endtask

  task automatic exp_store(input logic [22:0] addr, input logic [31:0] wd, input bit hit);
    if (hit) exp_ev(EV_DRAM, 1'b0, {23'd0, addr[10:4], addr[3:2]}, wd);
    exp_ev(EV_MEM, 1'b1, {9'd0, addr[22:2], 2'b00}, wd);
    exp_ev(EV_READY, 1'b1, 32'd0, 32'd0);
  endtask

  // Monitor: compares every observed event against the head of the scoreboard.
  task automatic observe(input ev_t o);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_%s: got %h expected none", o.kind.name(), o);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("ev_%s", e.kind.name()), o, e);
    end
  endtask

  always @(negedge clk) begin
    ev_t o;
    if (nReset) begin
      if (bus.mem_req && bus.mem_ack) begin
        o.kind = EV_MEM;
        o.w    = bus.mem_we;
        o.a    = {9'd0, bus.mem_addr};
        o.d    = bus.mem_we ? bus.mem_wdata : 32'd0;
        n_acks++;
        ack_cyc = cyc;
        observe(o);
      end
      if (bus.dram_we) begin
        o.kind = EV_DRAM;
        o.w    = 1'b0;
        o.a    = {23'd0, bus.dram_addr};
        o.d    = bus.dram_wdata;
        observe(o);
      end
      if (bus.tag_we) begin
        o.kind = EV_TAG;
        o.w    = 1'b0;
        o.a    = {25'd0, bus.tag_windex};
        o.d    = {20'd0, bus.tag_wdata};
        observe(o);
      end
      if (bus.cpu_ready) begin
        o.kind = EV_READY;
        o.w    = (exp_q.size() > 0 && exp_q[0].kind == EV_READY) ? exp_q[0].w : 1'b0;
        o.a    = 32'd0;
        o.d    = o.w ? 32'(cyc - ack_cyc) : 32'(cyc - req_cyc + 1);
        observe(o);
      end
      if (bus.tag_we && bus.tag_re) check("tag_we_re_exclusive", 1, 0);
    end
  end

  // Memory model: acknowledges each request after two cycles with address-derived data.
  initial begin
    int wcnt;
    wcnt          = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!nReset || bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wcnt        = 0;
      end else if (bus.mem_req) begin
        wcnt++;
        if (wcnt == 2) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mdat(bus.mem_addr);
          wcnt          = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Tag RAM model: registered read port over a 128-entry array, fed by the DUT's tag writes.
  logic [11:0] tag_mem [128];
  initial for (int i = 0; i < 128; i++) tag_mem[i] = 12'h000;
  always @(posedge clk) begin
    if (bus.tag_we) tag_mem[bus.tag_windex] <= bus.tag_wdata;
    if (bus.tag_re) bus.tag_rdata <= tag_mem[bus.tag_rindex];
  end
  initial bus.tag_rdata = '0;

  task automatic cpu_op(input string name, input logic we, input logic [22:0] addr,
                        input logic [31:0] wd);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    req_cyc       = cyc;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_done"}, done, 1);
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    int base;
    bit got;
    nReset        = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 23'h000010;
    bus.cpu_wdata = '0;
    #12;
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_cpu_busy", bus.cpu_busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_tag_we", bus.tag_we, 0);
    check("rst_dram_we", bus.dram_we, 0);
    check("rst_tag_re", bus.tag_re, 0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    nReset = 1'b1;

    exp_load(23'h000010, 1'b0);
    cpu_op("ld_miss_10", 1'b0, 23'h000010, 0);
    exp_load(23'h000014, 1'b1);
    cpu_op("ld_hit_14", 1'b0, 23'h000014, 0);
    exp_load(23'h000810, 1'b0);
    cpu_op("ld_conflict_810", 1'b0, 23'h000810, 0);
    exp_load(23'h000010, 1'b0);
    cpu_op("ld_remiss_10", 1'b0, 23'h000010, 0);
    exp_store(23'h000014, 32'hDEADBEEF, 1'b1);
    cpu_op("st_hit_14", 1'b1, 23'h000014, 32'hDEADBEEF);
    exp_load(23'h000014, 1'b1);
    cpu_op("ld_after_st_14", 1'b0, 23'h000014, 0);
    exp_store(23'h7FF000, 32'h1234_5678, 1'b0);
    cpu_op("st_miss_7ff000", 1'b1, 23'h7FF000, 32'h1234_5678);
    exp_load(23'h7FF000, 1'b0);
    cpu_op("ld_miss_7ff000", 1'b0, 23'h7FF000, 0);

    // Reset in the middle of a refill, right after its second ack.
    exp_refill(23'h000020, 2, 1'b0);
    @(posedge clk);
    #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 23'h000020;
    req_cyc      = cyc;
    base         = n_acks;
    got          = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #2;
      if (n_acks >= base + 2) begin
        got = 1'b1;
        break;
      end
    end
    check("mid_refill_2_acks", got, 1);
    nReset = 1'b0;
    #1;
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_busy", bus.cpu_busy, 0);
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    #1;
    check("post_rst_mem_req", bus.mem_req, 0);

    exp_load(23'h000020, 1'b0);
    cpu_op("ld_after_rst_20", 1'b0, 23'h000020, 0);
    exp_load(23'h000024, 1'b1);
    cpu_op("ld_hit_24", 1'b0, 23'h000024, 0);

    repeat (4) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
